halflife_timer: RTL and testbench

Parametrised up/down/load counter with a half-life decay mode.
- In decay mode the count halves (logical shift right by 1) once per programmable period until it reaches zero.
- Adds tick enable, wrap/saturate selection, terminal-count and error pulses.
- Sits in the top-level timer datapath; drives the displayed count and event flags.

---
 rtl/halflife_pkg.sv | 20 ++
 rtl/halflife_if.sv | 28 ++
 rtl/halflife_period_cnt.sv | 40 ++++
 rtl/halflife_timer.sv | 148 ++++++++++++++
 tb/tb_halflife_timer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/halflife_pkg.sv
// Shared types and command encodings for the half-life decay timer.
package halflife_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DECAY = 1'b1
  } state_e;

  // Command vector ordering is {up, down, load, decay}.
  localparam logic [3:0] CMD_NONE  = 4'b0000;
  localparam logic [3:0] CMD_UP    = 4'b1000;
  localparam logic [3:0] CMD_DOWN  = 4'b0100;
  localparam logic [3:0] CMD_LOAD  = 4'b0010;
  localparam logic [3:0] CMD_DECAY = 4'b0001;

  function automatic logic is_onehot(input logic [3:0] cmd);
    is_onehot = (cmd != 4'b0000) && ((cmd & (cmd - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/halflife_if.sv
// Command/status bundle between the timer datapath and the half-life timer.
interface halflife_if #(
  parameter int N = 8,
  parameter int P = 8
);
  logic         en;
  logic         up;
  logic         down;
  logic         load;
  logic         decay;
  logic [N-1:0] in;
  logic [P-1:0] period;
  logic [N-1:0] out;
  logic         zero;
  logic         tc;
  logic         err;
  logic         busy;

  modport master (
    output en, up, down, load, decay, in, period,
    input  out, zero, tc, err, busy
  );

  modport slave (
    input  en, up, down, load, decay, in, period,
    output out, zero, tc, err, busy
  );
endinterface

// File: rtl/halflife_period_cnt.sv
// P-bit decay period counter: counts enabled cycles and flags when the
// latched period is reached, wrapping back to zero on that hit.
module halflife_period_cnt #(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [P-1:0] period,
  output logic         hit
);

  logic [P-1:0] per_cnt_q;
  logic [P-1:0] per_cnt_d;

  assign hit = (per_cnt_q == period);

  // Next count: clear wins, a hit restarts the period, otherwise count up.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (clr) begin
      per_cnt_d = {P{1'b0}};
    end else if (en) begin
      per_cnt_d = hit ? {P{1'b0}} : (per_cnt_q + {{(P-1){1'b0}}, 1'b1});
    end else begin
      per_cnt_d = per_cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      per_cnt_q <= {P{1'b0}};
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

endmodule

// File: rtl/halflife_timer.sv
// Up/down/load counter with a half-life decay mode; owns the FSM and the
// count register, delegating period timing to halflife_period_cnt.
module halflife_timer
  import halflife_pkg::*;
#(
  parameter int N   = 8,
  parameter int P   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  halflife_if.slave  bus
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ZERO     = {N{1'b0}};
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic [P-1:0] period_q, period_d;
  logic         tc_q, tc_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;

  logic [3:0]   cmd_s;
  logic         cmd_illegal_s;
  logic [N-1:0] half_s;
  logic         cnt_clr_s;
  logic         cnt_en_s;
  logic         hit_s;

  assign cmd_s         = {bus.up, bus.down, bus.load, bus.decay};
  assign cmd_illegal_s = (cmd_s != CMD_NONE) && !is_onehot(cmd_s);
  assign half_s        = out_q >> 1;

  halflife_period_cnt #(.P(P)) u_period_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .period (period_q),
    .hit    (hit_s)
  );

  // Next-state logic; tc/err default low so they only ever pulse for a cycle.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    period_d  = period_q;
    tc_d      = 1'b0;
    err_d     = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          cnt_clr_s = 1'b1;
          case (cmd_s)
            CMD_NONE: out_d = out_q;
            CMD_LOAD: out_d = bus.in;
            CMD_UP: begin
              if (out_q == ALL_ONES) begin
                tc_d  = 1'b1;
                out_d = SAT ? out_q : ZERO;
              end else begin
                out_d = out_q + ONE;
              end
            end
            CMD_DOWN: begin
              if (out_q == ZERO) begin
                tc_d  = 1'b1;
                out_d = SAT ? out_q : ALL_ONES;
              end else begin
                out_d = out_q - ONE;
              end
            end
            CMD_DECAY: begin
              out_d    = bus.in;
              period_d = bus.period;
              state_d  = DECAY;
            end
            default: err_d = cmd_illegal_s;
          endcase
        end
        DECAY: begin
          if (cmd_s == CMD_LOAD) begin
            out_d     = bus.in;
            state_d   = IDLE;
            cnt_clr_s = 1'b1;
          end else begin
            // Stray commands are flagged but do not disturb the decay.
            err_d = (cmd_s != CMD_NONE);
            if (out_q == ZERO) begin
              state_d   = IDLE;
              tc_d      = 1'b1;
              cnt_clr_s = 1'b1;
            end else if (hit_s) begin
              cnt_en_s = 1'b1;
              out_d    = half_s;
              if (half_s == ZERO) begin
                state_d = IDLE;
                tc_d    = 1'b1;
              end else begin
                state_d = DECAY;
              end
            end else begin
              cnt_en_s = 1'b1;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_clr_s = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == DECAY);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      out_q    <= ZERO;
      period_q <= {P{1'b0}};
      tc_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      period_q <= period_d;
      tc_q     <= tc_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.zero = (out_q == ZERO);
  assign bus.tc   = tc_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_halflife_timer.sv
// Drives a wrapping and a saturating halflife_timer with identical stimulus
// and checks both against an arithmetic reference model every cycle.
module tb_halflife_timer;

  localparam logic [3:0] C_NONE  = 4'b0000;
  localparam logic [3:0] C_UP    = 4'b1000;
  localparam logic [3:0] C_DOWN  = 4'b0100;
  localparam logic [3:0] C_LOAD  = 4'b0010;
  localparam logic [3:0] C_DECAY = 4'b0001;

  logic       clk;
  logic       rst;
  logic       en, up, down, load, decay;
  logic [7:0] in_v;
  logic [7:0] period_v;

  int checks;
  int errors;

  // Reference model state, index 0 = wrap build, 1 = saturate build.
  int m_out [2];
  int m_cnt [2];
  int m_per [2];
  bit m_dec [2];
  bit m_tc  [2];
  bit m_err [2];

  halflife_if #(.N(8), .P(8)) bus0 ();
  halflife_if #(.N(8), .P(8)) bus1 ();

  assign bus0.en = en;     assign bus1.en = en;
  assign bus0.up = up;     assign bus1.up = up;
  assign bus0.down = down; assign bus1.down = down;
  assign bus0.load = load; assign bus1.load = load;
  assign bus0.decay = decay;     assign bus1.decay = decay;
  assign bus0.in = in_v;         assign bus1.in = in_v;
  assign bus0.period = period_v; assign bus1.period = period_v;

  halflife_timer #(.N(8), .P(8), .SAT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  halflife_timer #(.N(8), .P(8), .SAT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s sat=%0d t=%0t got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    cmp(name, 0, act, exp);
  endtask

  // Predict the state after the coming clock edge from the current inputs.
  task automatic model_update(input int k);
    int ncmd;
    ncmd = int'(up) + int'(down) + int'(load) + int'(decay);
    if (!rst) begin
      m_out[k] = 0; m_cnt[k] = 0; m_per[k] = 0;
      m_dec[k] = 1'b0; m_tc[k] = 1'b0; m_err[k] = 1'b0;
    end else if (!en) begin
      m_tc[k] = 1'b0; m_err[k] = 1'b0;
    end else if (!m_dec[k]) begin
      m_tc[k] = 1'b0; m_err[k] = 1'b0;
      if (ncmd > 1) m_err[k] = 1'b1;
      else if (load) m_out[k] = in_v;
      else if (up) begin
        if (m_out[k] == 255) begin
          m_tc[k] = 1'b1;
          if (k == 0) m_out[k] = 0;
        end else m_out[k] = m_out[k] + 1;
      end else if (down) begin
        if (m_out[k] == 0) begin
          m_tc[k] = 1'b1;
          if (k == 0) m_out[k] = 255;
        end else m_out[k] = m_out[k] - 1;
      end else if (decay) begin
        m_out[k] = in_v; m_per[k] = period_v; m_cnt[k] = 0; m_dec[k] = 1'b1;
      end
    end else begin
      m_tc[k] = 1'b0; m_err[k] = 1'b0;
      if (load && ncmd == 1) begin
        m_out[k] = in_v; m_dec[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        m_err[k] = (ncmd != 0);
        if (m_out[k] == 0) begin
          m_dec[k] = 1'b0; m_tc[k] = 1'b1; m_cnt[k] = 0;
        end else if (m_cnt[k] == m_per[k]) begin
          m_out[k] = m_out[k] / 2; m_cnt[k] = 0;
          if (m_out[k] == 0) begin m_dec[k] = 1'b0; m_tc[k] = 1'b1; end
        end else m_cnt[k] = m_cnt[k] + 1;
      end
    end
  endtask

  task automatic compare_all();
    cmp("out",  0, int'(bus0.out),  m_out[0]);
    cmp("zero", 0, int'(bus0.zero), int'(m_out[0] == 0));
    cmp("tc",   0, int'(bus0.tc),   int'(m_tc[0]));
    cmp("err",  0, int'(bus0.err),  int'(m_err[0]));
    cmp("busy", 0, int'(bus0.busy), int'(m_dec[0]));
    cmp("out",  1, int'(bus1.out),  m_out[1]);
    cmp("zero", 1, int'(bus1.zero), int'(m_out[1] == 0));
    cmp("tc",   1, int'(bus1.tc),   int'(m_tc[1]));
    cmp("err",  1, int'(bus1.err),  int'(m_err[1]));
    cmp("busy", 1, int'(bus1.busy), int'(m_dec[1]));
  endtask

  // One clock: apply inputs, advance the model, then check after the edge.
  task automatic step(input bit r, input bit e, input logic [3:0] c,
                      input logic [7:0] iv, input logic [7:0] pv);
    rst = r; en = e; up = c[3]; down = c[2]; load = c[1]; decay = c[0];
    in_v = iv; period_v = pv;
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic go(input logic [3:0] c, input logic [7:0] iv, input logic [7:0] pv);
    step(1'b1, 1'b1, c, iv, pv);
  endtask

  initial begin
    int seq [6];
    int prev;
    int sel;
    logic [3:0] c;
    logic [7:0] iv;
    checks = 0;
    errors = 0;
    seq = '{20, 10, 5, 2, 1, 0};
    rst = 1'b0; en = 1'b0; up = 1'b0; down = 1'b0; load = 1'b0; decay = 1'b0;
    in_v = 8'h00; period_v = 8'h00;
    @(negedge clk);
    step(1'b0, 1'b0, C_NONE, 8'h00, 8'h00);

    // Reset overrides a pending up
    go(C_LOAD, 8'h5A, 8'h00);
    lit("load_5a", int'(bus0.out), 8'h5A);
    step(1'b0, 1'b1, C_UP, 8'h00, 8'h00);
    lit("rst_out", int'(bus0.out), 0);
    lit("rst_busy", int'(bus0.busy), 0);
    lit("rst_tc", int'(bus0.tc), 0);
    lit("rst_err", int'(bus0.err), 0);
    lit("rst_zero", int'(bus0.zero), 1);

    // Upper limit: wrap vs saturate
    go(C_LOAD, 8'hFE, 8'h00);
    go(C_UP, 8'h00, 8'h00);
    lit("up1_w", int'(bus0.out), 8'hFF);
    lit("up1_s", int'(bus1.out), 8'hFF);
    go(C_UP, 8'h00, 8'h00);
    lit("up2_w", int'(bus0.out), 8'h00);
    lit("up2_wtc", int'(bus0.tc), 1);
    lit("up2_s", int'(bus1.out), 8'hFF);
    lit("up2_stc", int'(bus1.tc), 1);
    go(C_UP, 8'h00, 8'h00);
    lit("up3_w", int'(bus0.out), 8'h01);
    lit("up3_wtc", int'(bus0.tc), 0);
    lit("up3_s", int'(bus1.out), 8'hFF);
    lit("up3_stc", int'(bus1.tc), 1);

    // Lower limit
    go(C_LOAD, 8'h00, 8'h00);
    go(C_DOWN, 8'h00, 8'h00);
    lit("dn0_w", int'(bus0.out), 8'hFF);
    lit("dn0_s", int'(bus1.out), 8'h00);
    lit("dn0_stc", int'(bus1.tc), 1);

    // Illegal combination holds and flags err
    go(C_LOAD, 8'h05, 8'h00);
    go(C_UP | C_DOWN, 8'h00, 8'h00);
    lit("illegal_out", int'(bus0.out), 5);
    lit("illegal_err", int'(bus0.err), 1);
    go(C_DOWN, 8'h00, 8'h00);
    lit("down_out", int'(bus0.out), 4);
    lit("down_err", int'(bus0.err), 0);

    // Full decay from 40 with period 2
    go(C_DECAY, 8'd40, 8'd2);
    lit("dec_start", int'(bus0.out), 40);
    lit("dec_busy", int'(bus0.busy), 1);
    prev = 40;
    for (int i = 0; i < 6; i++) begin
      go(C_NONE, 8'h00, 8'd2);
      go(C_NONE, 8'h00, 8'd2);
      lit("dec_hold", int'(bus0.out), prev);
      go(C_NONE, 8'h00, 8'd2);
      lit("dec_half", int'(bus0.out), seq[i]);
      prev = seq[i];
    end
    lit("dec_tc", int'(bus0.tc), 1);
    lit("dec_done", int'(bus0.busy), 0);

    // Abort with load mid-decay
    go(C_DECAY, 8'd40, 8'd2);
    for (int i = 0; i < 6; i++) go(C_NONE, 8'h00, 8'd2);
    lit("abort_pre", int'(bus0.out), 10);
    go(C_LOAD, 8'h33, 8'd2);
    lit("abort_out", int'(bus0.out), 8'h33);
    lit("abort_busy", int'(bus0.busy), 0);
    lit("abort_tc", int'(bus0.tc), 0);
    go(C_UP, 8'h00, 8'd2);
    lit("abort_up", int'(bus0.out), 8'h34);

    // Freeze mid-decay; period change ignored
    go(C_DECAY, 8'd40, 8'd2);
    go(C_NONE, 8'h00, 8'd2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, C_UP, 8'h00, 8'd7);
    lit("frz_out", int'(bus0.out), 40);
    lit("frz_busy", int'(bus0.busy), 1);
    go(C_NONE, 8'h00, 8'd7);
    lit("frz_r1", int'(bus0.out), 40);
    go(C_NONE, 8'h00, 8'd7);
    lit("frz_r2", int'(bus0.out), 20);
    go(C_NONE, 8'h00, 8'd7);
    go(C_NONE, 8'h00, 8'd7);
    go(C_NONE, 8'h00, 8'd7);
    lit("frz_r3", int'(bus0.out), 10);
    for (int i = 0; i < 12; i++) go(C_NONE, 8'h00, 8'd0);

    // Decay from zero finishes on the next enabled cycle
    go(C_DECAY, 8'h00, 8'd5);
    lit("dz_busy", int'(bus0.busy), 1);
    go(C_NONE, 8'h00, 8'd5);
    lit("dz_done", int'(bus0.busy), 0);
    lit("dz_tc", int'(bus0.tc), 1);

    // Stray command during decay: err, halving continues
    go(C_DECAY, 8'd8, 8'd0);
    go(C_UP, 8'h00, 8'd0);
    lit("dstray_err", int'(bus0.err), 1);
    lit("dstray_out", int'(bus0.out), 4);
    go(C_NONE, 8'h00, 8'd0);
    lit("dstray_next", int'(bus0.out), 2);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      sel = int'($urandom_range(0, 15));
      if (sel < 7) c = C_NONE;
      else if (sel < 13) c = 4'(4'b0001 << $urandom_range(0, 3));
      else c = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 4))
        0: iv = 8'h00;
        1: iv = 8'h01;
        2: iv = 8'hFF;
        default: iv = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0), c, iv,
           8'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
